vend_controller: RTL and testbench
==================================

// Module: vend_controller
// PURPOSE
//  Credit/vend sequencer directly downstream of the coin decoder. It consumes the decoded coin
//  value, accumulates credit, checks the item selection against its price and drives a dispense
//  handshake. It then returns any remaining credit as change, one coin per handshake (10/5/1).
// PARAMETERS
//  CREDIT_W    8    credit register width; MAX_CREDIT <= 2**CREDIT_W-1
//  MAX_CREDIT  99   a coin that would push credit above this is rejected
//  PRICE_0     15   price of item 0 (all prices must be >= 1 and <= MAX_CREDIT)
//  PRICE_1     20   price of item 1
//  PRICE_2     25   price of item 2
//  PRICE_3     30   price of item 3
// PORTS
//  clk             in   1         system clock, rising edge
//  rst             in   1         synchronous, active-high reset
//  coin_valid      in   1         1-cycle strobe qualifying coin_value
//  coin_value      in   5         decoded coin: 1, 5 or 10 are legal; any other value is illegal
//  sel_valid       in   1         1-cycle strobe qualifying sel_item
//  sel_item        in   2         item index 0..3
//  cancel          in   1         1-cycle request to refund all credit
//  credit          out  CREDIT_W  current credit
//  coin_reject     out  1         1-cycle pulse: coin not accepted
//  insufficient    out  1         1-cycle pulse: selection refused because credit < price
//  dispense_valid  out  1         dispense request; held until accepted by dispense_ready
//  dispense_item   out  2         item being dispensed; stable while dispense_valid is high
//  dispense_ready  in   1         dispenser accepts the request
//  change_valid    out  1         change coin request; held until accepted by change_ready
//  change_coin     out  5         change coin value (10/5/1); stable while change_valid is high
//  change_ready    in   1         change hopper accepts the coin
//  busy            out  1         high in VEND or CHANGE
// BEHAVIOUR
//  - Reset: state=IDLE; credit, dispense_item and change_coin = 0; every valid and pulse output = 0.
//    Reset mid-VEND/CHANGE discards outstanding credit; no refund is issued.
//  - All outputs are driven from registers. There is no input-to-output combinational path.
//  - States: IDLE (credit==0), CREDIT (credit>0), VEND, CHANGE.
//  - Per-cycle input priority in IDLE/CREDIT: cancel > sel_valid > coin_valid.
//    A coin that arrives in the same cycle as cancel or sel_valid is rejected.
//  - Coin accept: in IDLE/CREDIT, coin_value is in {1,5,10} and credit+coin_value <= MAX_CREDIT.
//    The sum is computed at CREDIT_W+1 bits. The new credit is visible at cycle N+1 and the state
//    becomes CREDIT. Otherwise coin_reject pulses at N+1. Coins arriving in VEND/CHANGE are
//    always rejected.
//  - Selection:
//    - In CREDIT with credit >= PRICE[sel_item] at cycle N: credit -= price at N+1, dispense_item
//      is latched and the state becomes VEND.
//    - If credit < price, or sel_valid arrives in IDLE: insufficient pulses at N+1 and the state
//      is unchanged.
//    - sel_valid in VEND/CHANGE is ignored.
//  - VEND: dispense_valid=1. On the cycle where dispense_valid && dispense_ready: if credit>0 go
//    to CHANGE, else go to IDLE. dispense_valid drops on the following cycle.
//  - cancel in CREDIT goes to CHANGE. cancel in IDLE/VEND/CHANGE is ignored.
//  - CHANGE:
//    - change_valid=1. change_coin = 10 if credit>=10, else 5 if credit>=5, else 1 (greedy).
//    - On each change_valid && change_ready: credit -= change_coin.
//    - When that subtraction reaches 0, go to IDLE and change_valid drops on the next cycle.
//    - Credit changes only on a handshake, so change_coin is stable while stalled.
// STRUCTURE
//  - vend_pkg.vh (shared include): COIN_1/COIN_5/COIN_10 constants, state encodings,
//    ITEM_W=2, price index function.
//  - Sub-module change_picker: greedy coin selection from credit (pure combinational, registered
//    by the parent).
// TESTING
//  1. Reset, coins 10 then 5 -> credit 10, then 15; sel 0 -> credit 0, dispense_valid with item 0;
//     ready -> IDLE, no change.
//  2. Coins 10,10,5 (credit 25), sel 1 -> credit 5, dispense item 1; ready -> change_coin 5 once
//     -> IDLE.
//  3. Credit 17, cancel, change_ready held low 3 cycles -> change_coin 10 stable; then 5, 1, 1;
//     credit 0 -> IDLE.
//  4. coin_value 0 and 3 -> coin_reject, credit unchanged; credit 95 + coin 10 -> reject,
//     credit stays 95.
//  5. Credit 10, sel 0 -> insufficient, credit 10, state CREDIT; coin 5 + sel 0 same cycle ->
//     coin rejected and insufficient pulses.
//  6. rst during CHANGE (credit 12) -> next cycle credit 0, all valids 0, IDLE; coin during VEND
//     -> coin_reject.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared definitions for the vend controller slice.
// Contents: coin denominations, coin field width, item index width, FSM state
// encoding, a coin legality check and the item-to-price lookup.
package vend_pkg;

  localparam int ITEM_W = 2;
  localparam int COIN_W = 5;

  localparam logic [COIN_W-1:0] COIN_1  = 5'd1;
  localparam logic [COIN_W-1:0] COIN_5  = 5'd5;
  localparam logic [COIN_W-1:0] COIN_10 = 5'd10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CREDIT = 2'd1,
    ST_VEND   = 2'd2,
    ST_CHANGE = 2'd3
  } state_t;

  // Only the three real denominations are accepted from the decoder.
  function automatic logic coin_legal(input logic [COIN_W-1:0] v);
    return (v == COIN_1) || (v == COIN_5) || (v == COIN_10);
  endfunction

  // Item index to price; prices come in as parameters of the top.
  function automatic int price_of(input logic [ITEM_W-1:0] item,
                                  input int p0, input int p1,
                                  input int p2, input int p3);
    int price;
    case (item)
      2'd0:    price = p0;
      2'd1:    price = p1;
      2'd2:    price = p2;
      2'd3:    price = p3;
      default: price = p0;
    endcase
    return price;
  endfunction

endpackage

// File: rtl/vend_controller_change_picker.sv
// Greedy change coin selection (purely combinational; the parent registers it).
// Ports:
//   i_credit  in   CREDIT_W  credit still owed to the customer
//   o_coin    out  5         largest denomination not exceeding i_credit (0 if none)
module change_picker
  import vend_pkg::*;
#(
  parameter int CREDIT_W = 8
) (
  input  logic [CREDIT_W-1:0] i_credit,
  output logic [COIN_W-1:0]   o_coin
);

  // Pick 10, then 5, then 1; zero credit yields no coin.
  always_comb begin
    o_coin = 5'd0;
    if (i_credit >= CREDIT_W'(COIN_10)) begin
      o_coin = COIN_10;
    end else if (i_credit >= CREDIT_W'(COIN_5)) begin
      o_coin = COIN_5;
    end else if (i_credit != '0) begin
      o_coin = COIN_1;
    end else begin
      o_coin = 5'd0;
    end
  end

endmodule

// File: rtl/vend_controller.sv
// Credit/vend sequencer: accumulates decoded coins, prices a selection,
// drives the dispense handshake and pays out remaining credit as change.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   coin_valid/coin_value     decoded coin strobe and value
//   sel_valid/sel_item        selection strobe and item index
//   cancel                    refund request
//   credit                    current credit
//   coin_reject/insufficient  1-cycle status pulses
//   dispense_valid/_item/_ready   dispense handshake
//   change_valid/_coin/_ready     change handshake (one coin per transfer)
//   busy                      high while vending or paying change
// Every output comes straight from a register; next values are decided in
// one combinational process from the current state and inputs.
module vend_controller
  import vend_pkg::*;
#(
  parameter int CREDIT_W   = 8,
  parameter int MAX_CREDIT = 99,
  parameter int PRICE_0    = 15,
  parameter int PRICE_1    = 20,
  parameter int PRICE_2    = 25,
  parameter int PRICE_3    = 30
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_valid,
  input  logic [COIN_W-1:0]   coin_value,
  input  logic                sel_valid,
  input  logic [ITEM_W-1:0]   sel_item,
  input  logic                cancel,
  output logic [CREDIT_W-1:0] credit,
  output logic                coin_reject,
  output logic                insufficient,
  output logic                dispense_valid,
  output logic [ITEM_W-1:0]   dispense_item,
  input  logic                dispense_ready,
  output logic                change_valid,
  output logic [COIN_W-1:0]   change_coin,
  input  logic                change_ready,
  output logic                busy
);

  state_t              r_state;
  logic [CREDIT_W-1:0] r_credit;
  logic                r_coin_reject;
  logic                r_insufficient;
  logic                r_dispense_valid;
  logic [ITEM_W-1:0]   r_dispense_item;
  logic                r_change_valid;
  logic [COIN_W-1:0]   r_change_coin;
  logic                r_busy;

  state_t              w_state_nxt;
  logic [CREDIT_W-1:0] w_credit_nxt;
  logic [ITEM_W-1:0]   w_item_nxt;
  logic                w_reject_nxt;
  logic                w_insuf_nxt;
  logic [CREDIT_W:0]   w_sum;
  logic [CREDIT_W-1:0] w_price;
  logic [COIN_W-1:0]   w_pick;

  // One extra bit so a large coin cannot wrap past MAX_CREDIT.
  assign w_sum   = {1'b0, r_credit} + (CREDIT_W+1)'(coin_value);
  assign w_price = CREDIT_W'(price_of(sel_item, PRICE_0, PRICE_1, PRICE_2, PRICE_3));

  // The picker looks at next-cycle credit so the registered coin lines up
  // with change_valid on entry to CHANGE and after every payout.
  change_picker #(.CREDIT_W(CREDIT_W)) u_picker (
    .i_credit (w_credit_nxt),
    .o_coin   (w_pick)
  );

  // Next-state, next-credit and status pulse decisions.
  always_comb begin
    w_state_nxt  = r_state;
    w_credit_nxt = r_credit;
    w_item_nxt   = r_dispense_item;
    w_reject_nxt = 1'b0;
    w_insuf_nxt  = 1'b0;
    case (r_state)
      ST_IDLE, ST_CREDIT: begin
        if (cancel) begin
          // A coin riding along with cancel loses the priority contest.
          w_reject_nxt = coin_valid;
          if (r_state == ST_CREDIT) begin
            w_state_nxt = ST_CHANGE;
          end else begin
            w_state_nxt = r_state;
          end
        end else if (sel_valid) begin
          w_reject_nxt = coin_valid;
          if ((r_state == ST_CREDIT) && (r_credit >= w_price)) begin
            w_credit_nxt = r_credit - w_price;
            w_item_nxt   = sel_item;
            w_state_nxt  = ST_VEND;
          end else begin
            w_insuf_nxt = 1'b1;
          end
        end else if (coin_valid) begin
          if (coin_legal(coin_value) && (w_sum <= (CREDIT_W+1)'(MAX_CREDIT))) begin
            w_credit_nxt = w_sum[CREDIT_W-1:0];
            w_state_nxt  = ST_CREDIT;
          end else begin
            w_reject_nxt = 1'b1;
          end
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_VEND: begin
        w_reject_nxt = coin_valid;
        if (r_dispense_valid && dispense_ready) begin
          w_state_nxt = (r_credit != '0) ? ST_CHANGE : ST_IDLE;
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_CHANGE: begin
        w_reject_nxt = coin_valid;
        if (r_change_valid && change_ready) begin
          w_credit_nxt = r_credit - CREDIT_W'(r_change_coin);
          w_state_nxt  = (w_credit_nxt == '0) ? ST_IDLE : ST_CHANGE;
        end else begin
          w_state_nxt = r_state;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; valids and busy follow the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= ST_IDLE;
      r_credit         <= '0;
      r_coin_reject    <= 1'b0;
      r_insufficient   <= 1'b0;
      r_dispense_valid <= 1'b0;
      r_dispense_item  <= '0;
      r_change_valid   <= 1'b0;
      r_change_coin    <= '0;
      r_busy           <= 1'b0;
    end else begin
      r_state          <= w_state_nxt;
      r_credit         <= w_credit_nxt;
      r_coin_reject    <= w_reject_nxt;
      r_insufficient   <= w_insuf_nxt;
      r_dispense_valid <= (w_state_nxt == ST_VEND);
      r_dispense_item  <= w_item_nxt;
      r_change_valid   <= (w_state_nxt == ST_CHANGE);
      r_change_coin    <= (w_state_nxt == ST_CHANGE) ? w_pick : 5'd0;
      r_busy           <= (w_state_nxt == ST_VEND) || (w_state_nxt == ST_CHANGE);
    end
  end

  assign credit         = r_credit;
  assign coin_reject    = r_coin_reject;
  assign insufficient   = r_insufficient;
  assign dispense_valid = r_dispense_valid;
  assign dispense_item  = r_dispense_item;
  assign change_valid   = r_change_valid;
  assign change_coin    = r_change_coin;
  assign busy           = r_busy;

endmodule

// File: tb/tb_vend_controller.sv
// Self-checking bench for vend_controller: a small credit model predicts
// pulses and credit; dispensed items and change coins are queued when the
// stimulus is driven and compared as the DUT hands them over.
module tb_vend_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       coin_valid = 1'b0;
  logic [4:0] coin_value = 5'd0;
  logic       sel_valid = 1'b0;
  logic [1:0] sel_item = 2'd0;
  logic       cancel = 1'b0;
  logic [7:0] credit;
  logic       coin_reject;
  logic       insufficient;
  logic       dispense_valid;
  logic [1:0] dispense_item;
  logic       dispense_ready = 1'b0;
  logic       change_valid;
  logic [4:0] change_coin;
  logic       change_ready = 1'b0;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;
  int m_credit = 0;
  bit m_busy   = 1'b0;
  int q_item[$];
  int q_coin[$];

  always #5 clk = ~clk;

  vend_controller dut (
    .clk(clk), .rst(rst),
    .coin_valid(coin_valid), .coin_value(coin_value),
    .sel_valid(sel_valid), .sel_item(sel_item), .cancel(cancel),
    .credit(credit), .coin_reject(coin_reject), .insufficient(insufficient),
    .dispense_valid(dispense_valid), .dispense_item(dispense_item),
    .dispense_ready(dispense_ready),
    .change_valid(change_valid), .change_coin(change_coin),
    .change_ready(change_ready), .busy(busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Sample point: 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected change sequence for an amount: largest coin first.
  task automatic push_change(input int amount);
    int rem;
    rem = amount;
    while (rem > 0) begin
      if (rem >= 10) begin q_coin.push_back(10); rem -= 10; end
      else if (rem >= 5) begin q_coin.push_back(5); rem -= 5; end
      else begin q_coin.push_back(1); rem -= 1; end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    m_credit = 0;
    m_busy = 1'b0;
    q_item.delete();
    q_coin.delete();
    check_eq("rst_credit", credit, 0);
    check_eq("rst_dvalid", dispense_valid, 0);
    check_eq("rst_cvalid", change_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_pulses", {coin_reject, insufficient}, 0);
    check_eq("rst_item_coin", {dispense_item, change_coin}, 0);
  endtask

  task automatic do_coin(input int v);
    bit ok;
    ok = !m_busy && (v == 1 || v == 5 || v == 10) && (m_credit + v <= 99);
    if (ok) m_credit += v;
    coin_valid = 1'b1;
    coin_value = 5'(v);
    tick();
    coin_valid = 1'b0;
    check_eq("coin_credit", credit, m_credit);
    check_eq("coin_reject", coin_reject, !ok);
  endtask

  // Selection, optionally with a coin in the same cycle (that coin is lost).
  task automatic do_sel(input int item, input bit with_coin, input int cv);
    int price;
    bit ok;
    price = 15 + 5 * item;
    ok = !m_busy && (m_credit > 0) && (m_credit >= price);
    if (ok) begin
      m_credit -= price;
      q_item.push_back(item);
      push_change(m_credit);
      m_busy = 1'b1;
    end
    sel_valid = 1'b1;
    sel_item = 2'(item);
    coin_valid = with_coin;
    coin_value = 5'(cv);
    tick();
    sel_valid = 1'b0;
    coin_valid = 1'b0;
    check_eq("sel_credit", credit, m_credit);
    check_eq("sel_insufficient", insufficient, !ok);
    check_eq("sel_coin_reject", coin_reject, with_coin);
    check_eq("sel_dvalid", dispense_valid, ok);
    check_eq("sel_busy", busy, m_busy);
  endtask

  task automatic do_cancel();
    if (!m_busy && m_credit > 0) begin
      push_change(m_credit);
      m_busy = 1'b1;
    end
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check_eq("cancel_credit", credit, m_credit);
    check_eq("cancel_cvalid", change_valid, m_busy);
    check_eq("cancel_busy", busy, m_busy);
  endtask

  task automatic do_dispense(input int stall);
    int exp;
    logic [1:0] seen;
    check_eq("disp_valid", dispense_valid, 1);
    for (int i = 0; i < stall; i++) begin
      tick();
      check_eq("disp_stall_valid", dispense_valid, 1);
    end
    seen = dispense_item;
    dispense_ready = 1'b1;
    tick();
    dispense_ready = 1'b0;
    if (q_item.size() == 0) begin
      check_eq("disp_unexpected", 1, 0);
    end else begin
      exp = q_item.pop_front();
      check_eq("disp_item", seen, exp);
    end
    check_eq("disp_drop", dispense_valid, 0);
    if (m_credit == 0) m_busy = 1'b0;
    check_eq("disp_busy", busy, m_busy);
    check_eq("disp_cvalid", change_valid, m_credit > 0);
  endtask

  task automatic do_change(input int stall);
    int exp;
    logic [4:0] seen;
    bit first;
    first = 1'b1;
    while (q_coin.size() > 0) begin
      check_eq("chg_valid", change_valid, 1);
      if (first) begin
        seen = change_coin;
        for (int i = 0; i < stall; i++) begin
          tick();
          check_eq("chg_stall_coin", change_coin, seen);
        end
        first = 1'b0;
      end
      seen = change_coin;
      change_ready = 1'b1;
      tick();
      change_ready = 1'b0;
      exp = q_coin.pop_front();
      check_eq("chg_coin", seen, exp);
      m_credit -= exp;
      check_eq("chg_credit", credit, m_credit);
    end
    m_busy = 1'b0;
    check_eq("chg_done_valid", change_valid, 0);
    check_eq("chg_done_busy", busy, 0);
  endtask

  initial begin
    // 1: basic purchase, exact credit
    do_reset();
    do_coin(10);
    do_coin(5);
    do_sel(0, 1'b0, 0);
    do_dispense(0);

    // 2: purchase with change, item 1 held for two stall cycles
    do_coin(10);
    do_coin(10);
    do_coin(5);
    do_sel(1, 1'b0, 0);
    do_dispense(2);
    do_change(0);

    // 3: cancel with 17, hopper stalls 3 cycles on the first coin
    do_coin(10);
    do_coin(5);
    do_coin(1);
    do_coin(1);
    do_cancel();
    do_change(3);

    // 4: illegal coin values and MAX_CREDIT boundary
    do_coin(0);
    do_coin(3);
    do_coin(31);
    for (int i = 0; i < 9; i++) do_coin(10);
    do_coin(5);
    do_coin(10);
    for (int i = 0; i < 4; i++) do_coin(1);
    do_coin(1);
    do_cancel();
    do_change(0);

    // 5: insufficient credit, selection in IDLE, coin colliding with selection
    do_sel(2, 1'b0, 0);
    do_cancel();
    do_coin(10);
    do_sel(0, 1'b0, 0);
    do_sel(0, 1'b1, 5);
    tick();
    check_eq("pulse_clear", {coin_reject, insufficient}, 0);
    check_eq("after_insuf_credit", credit, 10);
    do_sel(3, 1'b0, 0);
    do_cancel();
    do_change(1);

    // 6: reset in the middle of paying change, then a coin during VEND
    do_coin(10);
    do_coin(1);
    do_coin(1);
    do_cancel();
    check_eq("pre_rst_coin", change_coin, 10);
    do_reset();
    do_coin(10);
    do_coin(10);
    do_coin(5);
    do_sel(2, 1'b0, 0);
    do_coin(5);
    check_eq("vend_coin_dvalid", dispense_valid, 1);
    do_dispense(0);
    check_eq("end_credit", credit, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
